exer_io2_mailbox: RTL and testbench

EXER_IO2_MAILBOX -- requirements
Module: exer_io2_mailbox

---
 rtl/exer_io2_mailbox.sv | 121 ++++++++++++
 tb/tb_exer_io2_mailbox.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/exer_io2_mailbox.sv
`default_nettype none
// ============================================================================
// Module   : exer_io2_mailbox
// Brief    : Byte mailbox from the main CPU (IO2 write) to the background CPU.
// Revision : 1.0  initial release
// ============================================================================
module exer_io2_mailbox #(
   parameter int DEPTH     = 4,
   parameter int HOLD_LAST = 1
)(
   input  logic       clk_sys,
   input  logic       RESET_n,
   input  logic       a_wr_n,
   input  logic [7:0] a_din,
   input  logic       a_clr,
   output logic [7:0] a_stat,
   input  logic       b_rd_n,
   output logic [7:0] b_dout,
   input  logic       b_clr,
   output logic [7:0] b_stat,
   output logic       b_nempty
);

   localparam int         c_PTR_W = $clog2(DEPTH);
   localparam logic [3:0] c_DEPTH = 4'(DEPTH);

   logic [7:0]         r_mem [DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [3:0]         r_count;
   logic               r_ovf;
   logic               r_udf;
   logic               r_wr_q;
   logic               r_rd_q;
   logic               r_wr_arm;
   logic               r_rd_arm;
   logic [7:0]         r_dout;
   logic [7:0]         r_a_stat;
   logic [7:0]         r_b_stat;

   logic               w_push;
   logic               w_pop;
   logic               w_full;
   logic               w_empty;
   logic               w_do_push;
   logic               w_do_pop;
   logic               w_ovf_set;
   logic               w_udf_set;
   logic [3:0]         w_count_nxt;

   // A strobe only counts after it has been seen idle since reset, so an
   // access interrupted by reset cannot complete afterwards.
   assign w_push    = r_wr_arm & r_wr_q & ~a_wr_n;
   assign w_pop     = r_rd_arm & ~r_rd_q & b_rd_n;
   assign w_full    = (r_count == c_DEPTH);
   assign w_empty   = (r_count == 4'd0);
   assign w_do_pop  = w_pop & ~w_empty;
   assign w_do_push = w_push & (~w_full | w_pop);
   assign w_ovf_set = w_push & w_full & ~w_pop;
   assign w_udf_set = w_pop & w_empty;

   always_comb begin
      w_count_nxt = r_count;
      case ({w_do_push, w_do_pop})
         2'b10:   w_count_nxt = r_count + 4'd1;
         2'b01:   w_count_nxt = r_count - 4'd1;
         default: w_count_nxt = r_count;
      endcase
   end

   always_ff @(posedge clk_sys or negedge RESET_n) begin
      if (!RESET_n) begin
         r_wr_q   <= 1'b1;
         r_rd_q   <= 1'b1;
         r_wr_arm <= 1'b0;
         r_rd_arm <= 1'b0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= 4'd0;
         r_ovf    <= 1'b0;
         r_udf    <= 1'b0;
      end else begin
         r_wr_q <= a_wr_n;
         r_rd_q <= b_rd_n;
         if (a_wr_n) r_wr_arm <= 1'b1;
         if (b_rd_n) r_rd_arm <= 1'b1;
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= w_count_nxt;
         if (w_ovf_set)  r_ovf <= 1'b1;
         else if (a_clr) r_ovf <= 1'b0;
         if (w_udf_set)  r_udf <= 1'b1;
         else if (b_clr) r_udf <= 1'b0;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk_sys) begin
      if (w_do_push) r_mem[r_wr_ptr] <= a_din;
   end

   always_ff @(posedge clk_sys or negedge RESET_n) begin
      if (!RESET_n) begin
         r_dout   <= 8'h00;
         r_a_stat <= 8'h20;
         r_b_stat <= 8'h20;
      end else begin
         if (!w_empty)            r_dout <= r_mem[r_rd_ptr];
         else if (HOLD_LAST == 0) r_dout <= 8'h00;
         r_a_stat <= {r_ovf, w_full, w_empty, 1'b0, r_count};
         r_b_stat <= {r_udf, w_full, w_empty, 1'b0, r_count};
      end
   end

   assign b_dout   = r_dout;
   assign a_stat   = r_a_stat;
   assign b_stat   = r_b_stat;
   assign b_nempty = (r_count != 4'd0);

endmodule
`default_nettype wire

// File: tb/tb_exer_io2_mailbox.sv
`default_nettype none
// ============================================================================
// Module   : tb_exer_io2_mailbox
// Brief    : Self-checking bench for exer_io2_mailbox (queue-based model).
// Revision : 1.0  initial release
// ============================================================================
module tb_exer_io2_mailbox;

   localparam int DEPTH     = 4;
   localparam int HOLD_LAST = 1;

   logic       clk_sys;
   logic       RESET_n;
   logic       a_wr_n;
   logic [7:0] a_din;
   logic       a_clr;
   logic [7:0] a_stat;
   logic       b_rd_n;
   logic [7:0] b_dout;
   logic       b_clr;
   logic [7:0] b_stat;
   logic       b_nempty;

   int n_tests = 0;
   int n_fail  = 0;

   exer_io2_mailbox #(.DEPTH(DEPTH), .HOLD_LAST(HOLD_LAST)) u_dut (
      .clk_sys (clk_sys),
      .RESET_n (RESET_n),
      .a_wr_n  (a_wr_n),
      .a_din   (a_din),
      .a_clr   (a_clr),
      .a_stat  (a_stat),
      .b_rd_n  (b_rd_n),
      .b_dout  (b_dout),
      .b_clr   (b_clr),
      .b_stat  (b_stat),
      .b_nempty(b_nempty)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: FIFO as a queue, strobes judged by their previous sampled level.
   byte unsigned mq[$];
   bit         m_ovf = 0, m_udf = 0;
   bit         m_prev_wr = 1, m_prev_rd = 1, m_wr_ok = 0, m_rd_ok = 0;
   logic [7:0] e_dout = 8'h00, e_astat = 8'h20, e_bstat = 8'h20;
   bit         m_en = 0;

   always @(posedge clk_sys or negedge RESET_n) begin
      bit push, pop;
      int n;
      if (!RESET_n) begin
         mq.delete();
         m_ovf = 0; m_udf = 0;
         m_prev_wr = 1; m_prev_rd = 1; m_wr_ok = 0; m_rd_ok = 0;
         e_dout = 8'h00; e_astat = 8'h20; e_bstat = 8'h20;
      end else begin
         push = m_wr_ok && m_prev_wr && !a_wr_n;
         pop  = m_rd_ok && !m_prev_rd && b_rd_n;
         n    = mq.size();
         e_astat = {m_ovf, n == DEPTH, n == 0, 1'b0, 4'(n)};
         e_bstat = {m_udf, n == DEPTH, n == 0, 1'b0, 4'(n)};
         if (n != 0)              e_dout = mq[0];
         else if (HOLD_LAST == 0) e_dout = 8'h00;
         if (push && n == DEPTH && !pop) m_ovf = 1;
         else if (a_clr)                 m_ovf = 0;
         if (pop && n == 0) m_udf = 1;
         else if (b_clr)    m_udf = 0;
         if (pop && n != 0) void'(mq.pop_front());
         if (push && (n < DEPTH || pop)) mq.push_back(a_din);
         m_prev_wr = a_wr_n;
         m_prev_rd = b_rd_n;
         if (a_wr_n) m_wr_ok = 1;
         if (b_rd_n) m_rd_ok = 1;
      end
   end

   always @(negedge clk_sys) begin
      if (m_en) begin
         check("cyc_b_dout", b_dout, e_dout);
         check("cyc_a_stat", a_stat, e_astat);
         check("cyc_b_stat", b_stat, e_bstat);
         check("cyc_b_nempty", {7'd0, b_nempty}, {7'd0, mq.size() != 0});
      end
   end

   task automatic do_push(input logic [7:0] d);
      @(negedge clk_sys);
      a_din  = d;
      a_wr_n = 1'b0;
      @(negedge clk_sys);
      a_wr_n = 1'b1;
      @(negedge clk_sys);
   endtask

   // chk_en selects whether the byte visible during the read is compared.
   task automatic do_pop(input logic chk_en, input logic [7:0] exp, input string name);
      @(negedge clk_sys);
      b_rd_n = 1'b0;
      @(negedge clk_sys);
      if (chk_en) check(name, b_dout, exp);
      b_rd_n = 1'b1;
      @(negedge clk_sys);
   endtask

   task automatic push_pop(input logic [7:0] d);
      @(negedge clk_sys);
      b_rd_n = 1'b0;
      @(negedge clk_sys);
      a_din  = d;
      a_wr_n = 1'b0;
      b_rd_n = 1'b1;
      @(negedge clk_sys);
      a_wr_n = 1'b1;
      @(negedge clk_sys);
   endtask

   task automatic pulse_clr(input logic side_b);
      @(negedge clk_sys);
      if (side_b) b_clr = 1'b1; else a_clr = 1'b1;
      @(negedge clk_sys);
      a_clr = 1'b0;
      b_clr = 1'b0;
   endtask

   initial begin
      a_wr_n = 1'b1; b_rd_n = 1'b1; a_din = 8'h00;
      a_clr = 1'b0; b_clr = 1'b0; RESET_n = 1'b1;
      #1 RESET_n = 1'b0;
      m_en = 1;
      repeat (2) @(negedge clk_sys);
      check("rst_a_stat", a_stat, 8'h20);
      check("rst_b_stat", b_stat, 8'h20);
      check("rst_b_dout", b_dout, 8'h00);
      RESET_n = 1'b1;
      repeat (2) @(negedge clk_sys);

      // Single push reaches the head.
      do_push(8'hA5);
      repeat (2) @(negedge clk_sys);
      check("push1_b_dout", b_dout, 8'hA5);
      check("push1_nempty", {7'd0, b_nempty}, 8'h01);
      check("push1_b_stat", b_stat, 8'h01);
      do_pop(1'b1, 8'hA5, "pop_a5");

      // Overflow: fifth byte dropped.
      do_push(8'h11); do_push(8'h22); do_push(8'h33); do_push(8'h44); do_push(8'h55);
      repeat (2) @(negedge clk_sys);
      check("ovf_a_stat", a_stat, 8'hC4);
      do_pop(1'b1, 8'h11, "ovf_pop0");
      do_pop(1'b1, 8'h22, "ovf_pop1");
      do_pop(1'b1, 8'h33, "ovf_pop2");
      do_pop(1'b1, 8'h44, "ovf_pop3");
      repeat (2) @(negedge clk_sys);
      check("ovf_drained_hold", b_dout, 8'h44);
      pulse_clr(1'b0);
      repeat (2) @(negedge clk_sys);
      check("ovf_cleared", a_stat, 8'h20);

      // Underflow with hold-last.
      do_push(8'h3C);
      do_pop(1'b1, 8'h3C, "pop_3c");
      do_pop(1'b0, 8'h00, "udf_pop");
      repeat (2) @(negedge clk_sys);
      check("udf_b_stat", b_stat, 8'hA0);
      check("udf_hold", b_dout, 8'h3C);
      pulse_clr(1'b1);
      repeat (2) @(negedge clk_sys);
      check("udf_cleared", b_stat, 8'h20);

      // Push and pop together while full.
      do_push(8'h01); do_push(8'h02); do_push(8'h03); do_push(8'h04);
      push_pop(8'h05);
      repeat (2) @(negedge clk_sys);
      check("fullpp_a_stat", a_stat, 8'h44);
      do_pop(1'b1, 8'h02, "fullpp_pop0");
      do_pop(1'b1, 8'h03, "fullpp_pop1");
      do_pop(1'b1, 8'h04, "fullpp_pop2");
      do_pop(1'b1, 8'h05, "fullpp_pop3");

      // Clear and overflow in the same clock: set wins.
      do_push(8'h61); do_push(8'h62); do_push(8'h63); do_push(8'h64);
      @(negedge clk_sys);
      a_din = 8'h99; a_wr_n = 1'b0; a_clr = 1'b1;
      @(negedge clk_sys);
      a_clr = 1'b0; a_wr_n = 1'b1;
      repeat (2) @(negedge clk_sys);
      check("clrset_a_stat", a_stat, 8'hC4);
      pulse_clr(1'b0);
      repeat (2) @(negedge clk_sys);
      check("clrset_cleared", a_stat, 8'h44);
      do_pop(1'b1, 8'h61, "clrset_pop0");
      do_pop(1'b1, 8'h62, "clrset_pop1");
      do_pop(1'b1, 8'h63, "clrset_pop2");
      do_pop(1'b1, 8'h64, "clrset_pop3");

      // Push and pop together while empty.
      push_pop(8'h7E);
      repeat (2) @(negedge clk_sys);
      check("emptypp_b_stat", b_stat, 8'h81);
      check("emptypp_b_dout", b_dout, 8'h7E);
      pulse_clr(1'b1);
      do_pop(1'b1, 8'h7E, "emptypp_pop");

      // Long write strobe yields one push.
      @(negedge clk_sys);
      a_din = 8'h77; a_wr_n = 1'b0;
      repeat (50) @(negedge clk_sys);
      a_wr_n = 1'b1;
      repeat (2) @(negedge clk_sys);
      check("long_wr_b_stat", b_stat, 8'h01);
      do_push(8'h88);
      repeat (2) @(negedge clk_sys);
      check("two_b_stat", b_stat, 8'h02);

      // Reset during a read.
      @(negedge clk_sys);
      b_rd_n = 1'b0;
      @(negedge clk_sys);
      #2 RESET_n = 1'b0;
      #1;
      check("midrst_a_stat", a_stat, 8'h20);
      check("midrst_b_stat", b_stat, 8'h20);
      check("midrst_b_dout", b_dout, 8'h00);
      check("midrst_nempty", {7'd0, b_nempty}, 8'h00);
      @(negedge clk_sys);
      RESET_n = 1'b1;
      repeat (5) @(negedge clk_sys);
      check("postrst_low_b_stat", b_stat, 8'h20);
      b_rd_n = 1'b1;
      repeat (3) @(negedge clk_sys);
      check("postrst_rise_b_stat", b_stat, 8'h20);
      do_pop(1'b0, 8'h00, "postrst_pop");
      repeat (2) @(negedge clk_sys);
      check("postrst_udf_b_stat", b_stat, 8'hA0);

      repeat (2) @(negedge clk_sys);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
